// File: rtl/grey_rate_mon_pkg.sv
// Shared definitions for the Grey-code rate monitor: Grey width, state
// encoding and the Grey-to-binary conversion helper.
package grey_rate_mon_pkg;

  localparam int GREY_W = 6;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Reflected Grey to binary: each binary bit is the XOR of all Grey bits
  // at and above it.
  function automatic logic [GREY_W-1:0] grey2bin(input logic [GREY_W-1:0] g);
    logic [GREY_W-1:0] b;
    b[GREY_W-1] = g[GREY_W-1];
    for (int i = GREY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/grey_sync2.sv
// Parameterised-width two-flop synchroniser with asynchronous reset.
// Safe for Grey-coded buses, where at most one bit changes per source step.
module grey_sync2 #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture of the foreign-domain bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/grey_rate_mon.sv
// Grey-code advance-rate monitor.
// A 6-bit Grey count from another clock domain is synchronised, converted to
// binary and its modulo-64 deltas are summed over WINDOW clk cycles. The sum
// is published on rate with a one-cycle rate_valid pulse per window.
// rate/rate_valid: rate_valid is a single-cycle pulse with no back-pressure;
// rate is registered with it and holds until the next pulse.
// Optional feature macro: GREY_RATE_MON_ERR_EN enables the sticky err flag for
// samples whose Grey value changed in more than one bit.
module grey_rate_mon
  import grey_rate_mon_pkg::*;
#(
  parameter  int WINDOW = 64,
  localparam int RATE_W = GREY_W + $clog2(WINDOW)
) (
`ifdef USE_POWER_PINS
  inout  wire                vccd1,
  inout  wire                vssd1,
`endif
  input  logic               clk,
  input  logic               rst,
  input  logic [GREY_W-1:0]  grey_in,
  input  logic               clr,
  output logic [RATE_W-1:0]  rate,
  output logic               rate_valid,
  output logic               err,
  output state_e             state_dbg
);

  localparam int              CNT_W    = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

  logic [GREY_W-1:0] g_s;
  logic [GREY_W-1:0] bin_s;
  logic [GREY_W-1:0] prev;
  logic [GREY_W-1:0] delta;
  logic [RATE_W-1:0] acc;
  logic [CNT_W-1:0]  win_cnt;
  logic              prime_cnt;
  logic              prime_done;
  logic              win_end;
  state_e            state;
  state_e            state_nxt;

  grey_sync2 #(.W(GREY_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (grey_in),
    .q   (g_s)
  );

  assign bin_s     = grey2bin(g_s);
  // 6-bit subtraction wraps naturally, so 63 -> 0 is an advance of 1.
  assign delta     = bin_s - prev;
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PRIME;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; clr overrides everything, including a window end.
  always_comb begin
    state_nxt  = state;
    prime_done = 1'b0;
    win_end    = 1'b0;
    if (clr) begin
      state_nxt = PRIME;
    end else begin
      case (state)
        PRIME: begin
          if (prime_cnt) begin
            prime_done = 1'b1;
            state_nxt  = RUN;
          end
        end
        RUN: begin
          win_end = (win_cnt == WIN_LAST);
        end
        default: state_nxt = PRIME;
      endcase
    end
  end

  // Window accumulation and result publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prime_cnt  <= 1'b0;
      prev       <= '0;
      acc        <= '0;
      win_cnt    <= '0;
      rate       <= '0;
      rate_valid <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      if (clr) begin
        prime_cnt <= 1'b0;
      end else if (state == PRIME) begin
        if (prime_done) begin
          prime_cnt <= 1'b0;
          prev      <= bin_s;
          acc       <= '0;
          win_cnt   <= '0;
        end else begin
          prime_cnt <= 1'b1;
        end
      end else begin
        prev <= bin_s;
        if (win_end) begin
          rate       <= acc + RATE_W'(delta);
          rate_valid <= 1'b1;
          acc        <= '0;
          win_cnt    <= '0;
        end else begin
          acc     <= acc + RATE_W'(delta);
          win_cnt <= win_cnt + 1'b1;
        end
      end
    end
  end

`ifdef GREY_RATE_MON_ERR_EN
  logic [GREY_W-1:0] g_prev;
  logic [GREY_W-1:0] g_diff;
  logic              multi_bit;

  // More than one set bit in the XOR means an incoherent sample.
  assign g_diff    = g_s ^ g_prev;
  assign multi_bit = |(g_diff & (g_diff - 1'b1));

  // Sticky incoherence flag; clr wins over a same-cycle error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_prev <= '0;
      err    <= 1'b0;
    end else begin
      g_prev <= g_s;
      if (clr) begin
        err <= 1'b0;
      end else if ((state == RUN) && multi_bit) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_grey_rate_mon.sv
// Bench for grey_rate_mon with WINDOW = 64.
// Optional feature macro: GREY_RATE_MON_ERR_EN changes the expected err value.
module tb_grey_rate_mon;

  localparam int WINDOW  = 64;
  localparam int RATE_W  = 12;
  localparam int LATENCY = 2 + WINDOW;
`ifdef GREY_RATE_MON_ERR_EN
  localparam int ERR_BUILT = 1;
`else
  localparam int ERR_BUILT = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic [5:0]        grey_in;
  logic [RATE_W-1:0] rate;
  logic              rate_valid;
  logic              err;
  grey_rate_mon_pkg::state_e state_dbg;

`ifdef USE_POWER_PINS
  wire vccd1 = 1'b1;
  wire vssd1 = 1'b0;
`endif

  grey_rate_mon #(.WINDOW(WINDOW)) dut (
`ifdef USE_POWER_PINS
    .vccd1      (vccd1),
    .vssd1      (vssd1),
`endif
    .clk        (clk),
    .rst        (rst),
    .grey_in    (grey_in),
    .clr        (clr),
    .rate       (rate),
    .rate_valid (rate_valid),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state.
  logic [RATE_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = 0;
  int first_cyc = 0;
  int start_cyc = 0;
  bit want_first = 1'b0;

  // Source model.
  int         period = 0;
  int         ph = 0;
  logic [5:0] src_bin = 6'd0;

  task automatic check(input string tag, input int got, input int exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp_v, cyc);
    end
  endtask

  // One clk cycle: observe outputs at the falling edge, then drive the source.
  task step();
    logic [RATE_W-1:0] e;
    @(negedge clk);
    if (rate_valid === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rate", int'(rate), int'(e));
        check("err_at_pulse", int'(err), 0);
        if (want_first) begin
          first_cyc  = cyc;
          want_first = 1'b0;
        end
      end
    end
    if (period > 0) begin
      if (ph >= period - 1) begin
        src_bin = src_bin + 6'd1;
        ph      = 0;
      end else begin
        ph++;
      end
    end
    grey_in = src_bin ^ (src_bin >> 1);
  endtask

  task wait_drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Restart the window with clr, run the source at one step per 'per' cycles
  // starting near the wrap point, expect nwin windows of exp_rate.
  task run_windows(input int per, input int nwin, input logic [RATE_W-1:0] exp_rate);
    clr     = 1'b1;
    period  = per;
    ph      = 0;
    src_bin = 6'd56;
    repeat (4) step();
    clr        = 1'b0;
    start_cyc  = cyc;
    want_first = 1'b1;
    for (int i = 0; i < nwin; i++) exp_q.push_back(exp_rate);
    wait_drain(nwin * WINDOW + 100);
    check("first_pulse_latency", first_cyc - start_cyc, LATENCY);
  endtask

  initial begin
    int pc;
    int n;
    rst     = 1'b1;
    clr     = 1'b0;
    grey_in = 6'd0;

    // Reset state.
    repeat (3) step();
    check("reset_rate", int'(rate), 0);
    check("reset_rate_valid", int'(rate_valid), 0);
    check("reset_err", int'(err), 0);
    check("reset_state", int'(state_dbg), int'(grey_rate_mon_pkg::PRIME));

    // Static input: zero rate, first pulse 66 cycles after release.
    rst        = 1'b0;
    start_cyc  = cyc;
    want_first = 1'b1;
    exp_q.push_back(RATE_W'(0));
    exp_q.push_back(RATE_W'(0));
    wait_drain(300);
    check("first_pulse_after_reset", first_cyc - start_cyc, LATENCY);

    // Source at clk, clk/2, clk/8; all cross the 63 -> 0 wrap.
    run_windows(1, 3, RATE_W'(64));

    // clr in the window-end cycle: no pulse, rate held, restart.
    n = 0;
    while (cyc != last_pulse_cyc + WINDOW - 1 && n < 2 * WINDOW) begin
      step();
      n++;
    end
    check("clr_align", cyc - last_pulse_cyc, WINDOW - 1);
    pc  = pulse_cnt;
    clr = 1'b1;
    step();
    clr = 1'b0;
    start_cyc = cyc;
    check("clr_window_end_no_pulse", pulse_cnt - pc, 0);
    check("clr_rate_held", int'(rate), 64);
    want_first = 1'b1;
    exp_q.push_back(RATE_W'(64));
    wait_drain(200);
    check("pulse_after_clr_latency", first_cyc - start_cyc, LATENCY);

    run_windows(2, 3, RATE_W'(32));
    run_windows(8, 3, RATE_W'(8));

    // Asynchronous reset while the pulse is still high.
    check("pulse_before_rst", int'(rate_valid), 1);
    check("rate_before_rst", int'(rate), 8);
    #2 rst = 1'b1;
    #1;
    check("rst_async_rate", int'(rate), 0);
    check("rst_async_rate_valid", int'(rate_valid), 0);
    check("rst_async_err", int'(err), 0);
    period  = 0;
    src_bin = 6'd0;
    pc = pulse_cnt;
    repeat (3) step();
    check("no_pulse_in_rst", pulse_cnt - pc, 0);
    rst        = 1'b0;
    start_cyc  = cyc;
    want_first = 1'b1;
    exp_q.push_back(RATE_W'(0));
    wait_drain(200);
    check("first_pulse_after_rst", first_cyc - start_cyc, LATENCY);

    // Incoherent jump 000000 -> 000011.
    clr     = 1'b1;
    period  = 0;
    src_bin = 6'd0;
    repeat (4) step();
    clr = 1'b0;
    repeat (10) step();
    check("err_clean", int'(err), 0);
    src_bin = 6'd2;
    repeat (5) step();
    check("err_set", int'(err), ERR_BUILT);
    repeat (20) step();
    check("err_sticky", int'(err), ERR_BUILT);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    check("err_cleared_by_clr", int'(err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
